// File: rtl/async_pkg.sv
// Shared types and default constants for the async_lib handshake boundary blocks.
package async_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FORK,
    ACK_HI,
    RELEASE
  } fork_state_t;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int TIMEOUT_DEF     = 1024;

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchroniser for an asynchronous handshake input.
module sync_ff #(
  parameter int stages = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [stages-1:0] r_ff;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its input from before the edge; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ff <= '0;
    else     r_ff <= {r_ff[stages-2:0], i_d};
  end

  assign o_q = r_ff[stages-1];

endmodule

// File: rtl/fork_sync_param.sv
// Clocked fork: broadcasts one 4-phase request to `size` branches and merges
// their acknowledges into a single upstream acknowledge, with a sticky timeout.
module fork_sync_param
  import async_pkg::*;
#(
  parameter int size           = 2,
  parameter int sync_stages    = SYNC_STAGES_DEF,
  parameter int timeout_cycles = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_in,
  output logic            ack_in,
  output logic [size-1:0] req_out,
  input  logic [size-1:0] ack_out,
  input  logic [size-1:0] en,
  output logic            busy,
  output logic            err
);

  localparam int              CW  = $clog2(timeout_cycles + 1);
  localparam logic [CW-1:0]   TMO = CW'(timeout_cycles);

  logic            w_req_s;
  logic [size-1:0] w_ack_s;

  sync_ff #(.stages(sync_stages)) u_sync_req (
    .clk (clk),
    .rst (rst),
    .i_d (req_in),
    .o_q (w_req_s)
  );

  for (genvar g = 0; g < size; g++) begin : g_ack_sync
    sync_ff #(.stages(sync_stages)) u_sync_ack (
      .clk (clk),
      .rst (rst),
      .i_d (ack_out[g]),
      .o_q (w_ack_s[g])
    );
  end

  fork_state_t     r_state,   w_state_nxt;
  logic [size-1:0] r_mask,    w_mask_nxt;
  logic [size-1:0] r_done,    w_done_nxt;
  logic [size-1:0] r_req_out, w_req_nxt;
  logic            r_ack_in,  w_ack_nxt;
  logic [CW-1:0]   r_cnt,     w_cnt_nxt;
  logic            r_err,     w_err_nxt;
  logic [size-1:0] w_done_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_mask    <= '0;
      r_done    <= '0;
      r_req_out <= '0;
      r_ack_in  <= 1'b0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_mask    <= w_mask_nxt;
      r_done    <= w_done_nxt;
      r_req_out <= w_req_nxt;
      r_ack_in  <= w_ack_nxt;
      r_cnt     <= w_cnt_nxt;
      r_err     <= w_err_nxt;
    end
  end

  // NOTE: every signal gets its hold value before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    w_done_nxt  = r_done;
    w_req_nxt   = r_req_out;
    w_ack_nxt   = r_ack_in;
    w_done_acc  = r_done | (r_mask & w_ack_s);

    unique case (r_state)
      IDLE: begin
        if (w_req_s) begin
          w_mask_nxt = en;
          w_req_nxt  = en;
          w_done_nxt = ~en;
          if (en == '0) begin
            w_state_nxt = ACK_HI;
            w_ack_nxt   = 1'b1;
          end else begin
            w_state_nxt = FORK;
          end
        end
      end
      FORK: begin
        // The completion test uses this cycle's acks so ack_in follows the
        // last branch by a single cycle.
        w_done_nxt = w_done_acc;
        if (&w_done_acc) begin
          w_ack_nxt   = 1'b1;
          w_state_nxt = ACK_HI;
        end
      end
      ACK_HI: begin
        if (!w_req_s) begin
          w_req_nxt   = '0;
          w_state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        if ((w_ack_s & r_mask) == '0) begin
          w_ack_nxt   = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    w_cnt_nxt = r_cnt;
    w_err_nxt = r_err;
    if (w_state_nxt != r_state) begin
      w_cnt_nxt = '0;
    end else if ((r_state == FORK || r_state == RELEASE) && r_cnt != TMO) begin
      w_cnt_nxt = r_cnt + CW'(1);
    end
    if (w_cnt_nxt == TMO) w_err_nxt = 1'b1;
  end

  assign req_out = r_req_out;
  assign ack_in  = r_ack_in;
  assign err     = r_err;
  assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_fork_sync_param.sv
// Self-checking bench for fork_sync_param: vector table, timed corner-case
// sequences and randomized handshakes against an event-time reference model.
module tb_fork_sync_param;

  localparam int N   = 4;
  localparam int SS  = 2;
  localparam int LAT = SS + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_in;
  logic [N-1:0] ack_out;
  logic [N-1:0] en;

  logic         ack_in, busy, err;
  logic [N-1:0] req_out;
  logic         ack_in_t, busy_t, err_t;
  logic [N-1:0] req_out_t;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fork_sync_param #(.size(N), .sync_stages(SS), .timeout_cycles(1024)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_in  (req_in),
    .ack_in  (ack_in),
    .req_out (req_out),
    .ack_out (ack_out),
    .en      (en),
    .busy    (busy),
    .err     (err)
  );

  fork_sync_param #(.size(N), .sync_stages(SS), .timeout_cycles(16)) dut_to (
    .clk     (clk),
    .rst     (rst),
    .req_in  (req_in),
    .ack_in  (ack_in_t),
    .req_out (req_out_t),
    .ack_out (ack_out),
    .en      (en),
    .busy    (busy_t),
    .err     (err_t)
  );

  typedef struct {
    logic [N-1:0] en;
    logic [N-1:0] acks;
    logic [N-1:0] exp_req;
    logic         exp_ack;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    req_in  = 1'b0;
    ack_out = '0;
    en      = '0;
    rst     = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  // One full handshake driven from a table record.
  task automatic run_vec(input vec_t v);
    en     = v.en;
    req_in = 1'b1;
    step(LAT);
    check("tbl req_out", req_out, v.exp_req);
    ack_out = v.acks;
    step(LAT);
    check("tbl ack_in", ack_in, v.exp_ack);
    if (!v.exp_ack) begin
      ack_out = v.acks | v.en;
      step(LAT);
      check("tbl ack_in late", ack_in, 1);
    end
    req_in = 1'b0;
    step(LAT - 1);
    check("tbl req_out held", req_out, v.en);
    step(1);
    check("tbl req_out released", req_out, 0);
    ack_out = '0;
    step(LAT);
    check("tbl ack_in rtz", ack_in, 0);
    step(1);
    check("tbl busy idle", busy, 0);
  endtask

  // Expected waveform from event times: req_out is up from LAT after the
  // request until LAT after its release; ack_in spans [rise, fall).
  task automatic run_random(input int ntx);
    logic [N-1:0] ren, exp_req;
    int a_t[N];
    int d_t[N];
    int rise, rel, fall;
    for (int k = 0; k < ntx; k++) begin
      ren  = N'($urandom_range(0, (1 << N) - 1));
      rise = LAT;
      for (int i = 0; i < N; i++) begin
        a_t[i] = LAT + $urandom_range(0, 8);
        if (ren[i] && a_t[i] + LAT > rise) rise = a_t[i] + LAT;
      end
      rel  = rise + $urandom_range(0, 5);
      fall = rel + LAT + 1;
      for (int i = 0; i < N; i++) begin
        d_t[i] = rel + LAT + $urandom_range(0, 8);
        if (ren[i] && d_t[i] + LAT > fall) fall = d_t[i] + LAT;
      end
      en = ren;
      for (int t = 0; t <= fall + 1; t++) begin
        exp_req = (t >= LAT && t < rel + LAT) ? ren : '0;
        check("rnd req_out", req_out, exp_req);
        check("rnd ack_in", ack_in, (t >= rise && t < fall) ? 1 : 0);
        check("rnd busy", busy, (t >= LAT && t < fall) ? 1 : 0);
        req_in = (t < rel);
        for (int i = 0; i < N; i++) begin
          if (ren[i]) ack_out[i] = (t >= a_t[i] && t < d_t[i]);
          else        ack_out[i] = 1'($urandom_range(0, 1));
        end
        step(1);
      end
      check("rnd err", err, 0);
      check("rnd err_t", err_t, 0);
      ack_out = '0;
      step(LAT + 1);
    end
  endtask

  initial begin
    vecs[0] = '{4'b1111, 4'b1111, 4'b1111, 1'b1};
    vecs[1] = '{4'b0101, 4'b1111, 4'b0101, 1'b1};
    vecs[2] = '{4'b0101, 4'b1010, 4'b0101, 1'b0};
    vecs[3] = '{4'b0000, 4'b0000, 4'b0000, 1'b1};
    vecs[4] = '{4'b1000, 4'b0111, 4'b1000, 1'b0};
    vecs[5] = '{4'b0011, 4'b0001, 4'b0011, 1'b0};

    // Reset state
    req_in = 1'b0; ack_out = '0; en = 4'b1111; rst = 1'b1;
    step(2);
    check("rst req_out", req_out, 0);
    check("rst ack_in", ack_in, 0);
    check("rst busy", busy, 0);
    check("rst err", err, 0);
    rst = 1'b0;
    step(1);

    // Staggered acks, mid-phase en change, staggered release
    en = 4'b1111;
    for (int t = 0; t <= 40; t++) begin
      if (t == 2)  check("launch early", req_out, 0);
      if (t == 3)  check("launch", req_out, 4'hf);
      if (t == 8)  check("en change ignored", req_out, 4'hf);
      if (t == 22) check("ack_in before last", ack_in, 0);
      if (t == 22) check("req_out held", req_out, 4'hf);
      if (t == 23) check("ack_in after last", ack_in, 1);
      if (t == 27) check("release early", req_out, 4'hf);
      if (t == 28) check("release", req_out, 0);
      if (t == 38) check("rtz early", ack_in, 1);
      if (t == 39) check("rtz", ack_in, 0);
      if (t == 40) check("busy after rtz", busy, 0);
      if (t == 0)  req_in = 1'b1;
      if (t == 5)  en = 4'b0000;
      if (t == 10) ack_out[0] = 1'b1;
      if (t == 12) ack_out[1] = 1'b1;
      if (t == 15) ack_out[2] = 1'b1;
      if (t == 20) ack_out[3] = 1'b1;
      if (t == 25) req_in = 1'b0;
      if (t == 30) ack_out[2] = 1'b0;
      if (t == 31) ack_out[0] = 1'b0;
      if (t == 33) ack_out[3] = 1'b0;
      if (t == 36) ack_out[1] = 1'b0;
      step(1);
    end

    // Vector table
    do_reset();
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Timeout with branch 2 silent, then late completion
    do_reset();
    en = 4'b1111;
    for (int t = 0; t <= 38; t++) begin
      if (t == 18) check("err before timeout", err_t, 0);
      if (t == 19) check("err at timeout", err_t, 1);
      if (t == 19) check("still waiting", ack_in_t, 0);
      if (t == 28) check("late ack_in", ack_in_t, 1);
      if (t == 28) check("err sticky", err_t, 1);
      if (t == 28) check("long timeout no err", err, 0);
      if (t == 33) check("timeout release", req_out_t, 0);
      if (t == 37) check("timeout rtz", ack_in_t, 0);
      if (t == 38) check("timeout idle", busy_t, 0);
      if (t == 38) check("err sticky idle", err_t, 1);
      if (t == 0)  req_in = 1'b1;
      if (t == 3)  ack_out = 4'b1011;
      if (t == 25) ack_out[2] = 1'b1;
      if (t == 30) req_in = 1'b0;
      if (t == 34) ack_out = '0;
      step(1);
    end

    // Asynchronous reset mid-FORK, then a normal handshake
    do_reset();
    en = 4'b1111;
    req_in = 1'b1;
    step(LAT + 20);
    check("pre-reset busy", busy, 1);
    check("pre-reset err_t", err_t, 1);
    #2 rst = 1'b1;
    #1;
    check("async rst req_out", req_out, 0);
    check("async rst ack_in", ack_in, 0);
    check("async rst busy", busy, 0);
    check("async rst err_t", err_t, 0);
    check("async rst req_out_t", req_out_t, 0);
    req_in = 1'b0;
    step(1);
    rst = 1'b0;
    step(1);
    run_vec(vecs[0]);

    // Randomized handshakes against the event-time model
    do_reset();
    run_random(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fork_sync_param.md
# fork_sync_param

Clocked parametric fork controller. It takes one 4-phase request and broadcasts it to `size` downstream branches. Branch acknowledges are collected into a single upstream acknowledge, so it is the distribution counterpart of the Muller-based join. It sits at the boundary between the synchronous control domain and the async_lib handshake channels. All handshake inputs are synchronised, and all outputs are registered.

## Interface
Parameters:
- `size`, 2, number of output branches (≥1)
- `sync_stages`, 2, flip-flop stages on each incoming handshake signal (≥2)
- `timeout_cycles`, 1024, cycles a phase may wait before `err` is raised (≥1)

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_in`  in  1  upstream 4-phase request (asynchronous)
- `ack_in`  out  1  upstream acknowledge
- `req_out`  out  size  per-branch request
- `ack_out`  in  size  per-branch acknowledge (asynchronous)
- `en`  in  size  branch enable mask, sampled at fork start (synchronous)
- `busy`  out  1  high whenever the state is not IDLE
- `err`  out  1  sticky timeout flag

## Operation
- Synchronisation:
  - `req_in` and each `ack_out[i]` pass through a `sync_stages`-deep synchroniser.
  - The FSM only ever sees the synchronised versions, `req_s` and `ack_s[i]`.
- Reset: every output is 0, the FSM is in IDLE, the mask register, done vector and counter are 0, and the synchroniser flops are 0.
- States:
  - IDLE → FORK when `req_s`=1:
    - latch `mask` <= `en`;
    - `req_out` <= `en`;
    - `done[i]` <= ~`en[i]`.
  - IDLE, special case: if `en`=0 at that point, go directly to ACK_HI with `ack_in` <= 1. A fully masked fork completes immediately.
  - FORK:
    - each cycle, `done[i]` <= `done[i]` | (`mask[i]` & `ack_s[i]`);
    - when `done` is all ones, set `ack_in` <= 1 and go to ACK_HI.
  - ACK_HI → RELEASE when `req_s`=0; `req_out` <= 0 on that transition.
  - RELEASE: when (`ack_s` & `mask`) = 0, set `ack_in` <= 0 and go to IDLE.
- Branch behaviour:
  - a branch that acks early holds its `req_out` high until RELEASE; the fork never withdraws a request mid-phase;
  - `ack_s[i]` on masked-off branches is ignored in every state.
- Timeout:
  - counter clears on every state change and counts in FORK and RELEASE;
  - when it reaches `timeout_cycles`, `err` <= 1 and the counter saturates;
  - the FSM keeps waiting;
  - `err` clears only on `rst`.
- Protocol violations:
  - `req_s` falling in FORK is ignored until ACK_HI is reached;
  - `en` changes outside the IDLE→FORK edge have no effect.
- Reset mid-operation: all outputs drop to 0 asynchronously, and the FSM returns to IDLE. Branches must tolerate a request withdrawn without acknowledge.

## Timing
- Input path: an edge on `req_in` or `ack_out[i]` becomes visible to the FSM `sync_stages` cycles later.
- Request launch:
  - `req_out` rises one cycle after `req_s` is seen high in IDLE;
  - total `sync_stages`+1 cycles from the `req_in` edge.
- Acknowledge:
  - `ack_in` rises one cycle after the last enabled `ack_s[i]` is seen;
  - total `sync_stages`+1 cycles from the slowest `ack_out` edge;
  - when all branches ack in the same cycle, `done` and `ack_in` behave as for a single late branch.
- Release: `req_out` falls `sync_stages`+1 cycles after `req_in` falls.
- Return to zero: `ack_in` falls `sync_stages`+1 cycles after the last enabled `ack_out` falls.
- `busy` is combinational from state.
- Minimum full handshake, for zero-delay branches: 4·(`sync_stages`+1) cycles.

## Structure
- `async_pkg` holds:
  - `fork_state_t` enum (IDLE, FORK, ACK_HI, RELEASE);
  - shared default constants `SYNC_STAGES_DEF` and `TIMEOUT_DEF`.
- Sub-module `sync_ff #(.stages)`: single-bit multi-flop synchroniser with asynchronous active-high reset to 0, instantiated `size`+1 times.
- Counter width is $clog2(`timeout_cycles`+1).

## Test plan
- Reset, `size`=4, `en`=4'b1111: raise `req_in` → `req_out`=4'b1111 at cycle 3. Ack branches at cycles 10, 12, 15, 20 → `ack_in`=1 at cycle 23, not before.
- Release: drop `req_in` → `req_out`=0 after 3 cycles. Drop branch acks at staggered times → `ack_in`=0 three cycles after the last drop; `busy`=0 the next cycle.
- Mask: `en`=4'b0101, with branches 1 and 3 acking spuriously → only `req_out[0]` and `req_out[2]` assert; `ack_in` depends only on branches 0 and 2.
- `en`=0 → `ack_in`=1 with `req_out`=0 throughout; full handshake completes.
- Timeout: `timeout_cycles`=16, branch 2 never acks → `err`=1 at cycle 16 of FORK. Then ack branch 2 → handshake completes and `err` stays 1.
- Assert `rst` during FORK → `req_out`, `ack_in`, `busy` and `err` are 0 immediately; a new request after reset completes normally.
